hazard_controller: RTL

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

---
 rtl/hazard_controller.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/hazard_controller.sv
// hazard_controller
//   Pipeline hazard unit for an in-order core that resolves branches in ID.
//   It detects load-use and branch-operand hazards, stalls for one or two
//   cycles, flushes IF/ID on a taken branch and freezes the pipe while data
//   memory is busy. All outputs are combinational from the current state and
//   inputs, so the unit adds no latency.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   IF_ID_RegisterRs1/Rs2       sources of the instruction in ID
//   IF_ID_UsesRs2               ID instruction reads rs2
//   IF_ID_Branch                ID instruction is a branch/jalr resolved in ID
//   branch_taken                ID branch/jump redirects the PC
//   ID_EX_MemRead/RegWrite/Rd   producer in EX
//   EX_MEM_MemRead/Rd           producer in MEM
//   dmem_busy                   data memory not ready
//   PC_Write, IF_ID_Write       front-end stage enables
//   IF_ID_Flush, ID_EX_Bubble   squash IF/ID instruction, zero ID/EX controls
//   Pipe_Freeze                 hold EX/MEM and MEM/WB
//
// Build option
//   HAZARD_PERF_EN adds saturating 16-bit counters stall_cycles and
//   flush_count. Without it those ports and their logic are absent.
module hazard_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] IF_ID_RegisterRs1,
  input  logic [4:0] IF_ID_RegisterRs2,
  input  logic       IF_ID_UsesRs2,
  input  logic       IF_ID_Branch,
  input  logic       branch_taken,
  input  logic       ID_EX_MemRead,
  input  logic       ID_EX_RegWrite,
  input  logic [4:0] ID_EX_RegisterRd,
  input  logic       EX_MEM_MemRead,
  input  logic [4:0] EX_MEM_RegisterRd,
  input  logic       dmem_busy,
  output logic       PC_Write,
  output logic       IF_ID_Write,
  output logic       IF_ID_Flush,
  output logic       ID_EX_Bubble,
  output logic       Pipe_Freeze
`ifdef HAZARD_PERF_EN
  ,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_count
`endif
);

  typedef enum logic [1:0] {RUN, HOLD, FREEZE} state_e;

  state_e     state_q, state_d;
  state_e     saved_q, saved_d;
  state_e     eff_state;
  logic [1:0] cnt_q, cnt_d;
  logic [1:0] hz_len;
  logic       ex_match, mem_match;
  logic       stall, flush;

  // x0 is hardwired zero and never creates a dependency.
  assign ex_match  = (ID_EX_RegisterRd != 5'd0) &&
                     ((ID_EX_RegisterRd == IF_ID_RegisterRs1) ||
                      (IF_ID_UsesRs2 && (ID_EX_RegisterRd == IF_ID_RegisterRs2)));
  assign mem_match = (EX_MEM_RegisterRd != 5'd0) &&
                     ((EX_MEM_RegisterRd == IF_ID_RegisterRs1) ||
                      (IF_ID_UsesRs2 && (EX_MEM_RegisterRd == IF_ID_RegisterRs2)));

  // Branch in ID needs its operands one stage earlier than an ALU op, so a
  // load feeding a branch costs two bubbles.
  always_comb begin
    hz_len = 2'd0;
    if (IF_ID_Branch && ID_EX_MemRead && ex_match)       hz_len = 2'd2;
    else if (ID_EX_MemRead && ex_match)                  hz_len = 2'd1;
    else if (IF_ID_Branch && ID_EX_RegWrite && ex_match) hz_len = 2'd1;
    else if (IF_ID_Branch && EX_MEM_MemRead && mem_match) hz_len = 2'd1;
  end

  // The first cycle out of FREEZE behaves exactly like the saved state, so
  // unfreezing never costs an extra bubble.
  assign eff_state = (state_q == FREEZE) ? saved_q : state_q;

  always_comb begin
    state_d      = state_q;
    saved_d      = saved_q;
    cnt_d        = cnt_q;
    stall        = 1'b0;
    flush        = 1'b0;
    PC_Write     = 1'b1;
    IF_ID_Write  = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Bubble = 1'b0;
    Pipe_Freeze  = 1'b0;
    if (!rst_n) begin
      PC_Write     = 1'b0;
      IF_ID_Write  = 1'b0;
      IF_ID_Flush  = 1'b1;
      ID_EX_Bubble = 1'b1;
    end else if (dmem_busy) begin
      // Remember where we came from only on entry; cnt is held.
      state_d     = FREEZE;
      if (state_q != FREEZE) saved_d = state_q;
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      Pipe_Freeze = 1'b1;
    end else begin
      saved_d = RUN;
      case (eff_state)
        HOLD: begin
          stall   = 1'b1;
          cnt_d   = (cnt_q == 2'd0) ? 2'd0 : cnt_q - 2'd1;
          state_d = (cnt_d == 2'd0) ? RUN : HOLD;
        end
        default: begin
          if (hz_len != 2'd0) begin
            stall   = 1'b1;
            state_d = (hz_len == 2'd2) ? HOLD : RUN;
            cnt_d   = (hz_len == 2'd2) ? 2'd1 : 2'd0;
          end else begin
            state_d = RUN;
            flush   = branch_taken;
          end
        end
      endcase
      PC_Write     = ~stall;
      IF_ID_Write  = ~stall;
      ID_EX_Bubble = stall;
      IF_ID_Flush  = flush;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      saved_q <= RUN;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_PERF_EN
  // stall/flush are only ever set in non-frozen, out-of-reset cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= 16'd0;
      flush_count  <= 16'd0;
    end else begin
      if (stall && (stall_cycles != 16'hFFFF)) stall_cycles <= stall_cycles + 16'd1;
      if (flush && (flush_count != 16'hFFFF))  flush_count  <= flush_count + 16'd1;
    end
  end
`endif

endmodule
